cdb_arbiter: RTL
================

# cdb_arbiter

Shares the single execution-result broadcast bus between the ALU and the load/store buffer (LSB). Each producer writes into a private result FIFO. A round-robin arbiter then drains one result per cycle onto the bus, which feeds ROB, RS and LSB wake-up. The block sits between the execute units and the result consumers and absorbs same-cycle collisions without stalling either unit.

## Interface
- DEPTH, 4, entries per producer FIFO (power of two, ≥2)
- RENAME_W, 4, ROB tag width
- DATA_W, 32, result value width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low freezes all state
- clear  in  1  misprediction flush, synchronous
- alu_valid  in  1  ALU result present this cycle
- alu_rename  in  RENAME_W  ALU result tag
- alu_value  in  DATA_W  ALU result
- alu_full  out  1  ALU FIFO holds DEPTH entries
- lsb_valid  in  1  load result present
- lsb_rename  in  RENAME_W  load tag
- lsb_value  in  DATA_W  load data
- lsb_full  out  1  LSB FIFO holds DEPTH entries
- cdb_valid  out  1  bus carries a result
- cdb_rename  out  RENAME_W  broadcast tag
- cdb_value  out  DATA_W  broadcast value
- cdb_src  out  1  0 = ALU, 1 = LSB

## Operation
- Push: `x_valid & !x_full & rdy & !clear` enqueues at the clock edge. A push while full is dropped; producers must honour `x_full`.
- Arbitration is combinational over the FIFO heads (and over the bypass inputs, see Configuration):
  - one head valid → that head is granted;
  - both heads valid → grant the source not granted last; the `last_grant` register updates on each grant.
- Bus outputs:
  - `cdb_valid = rdy & !clear & grant_any`;
  - `cdb_rename`, `cdb_value` and `cdb_src` reflect the granted head;
  - when `cdb_valid` is 0, the bus outputs are driven to 0.
- Pop: the granted FIFO pops at the edge when `cdb_valid` is 1.
- Per-FIFO counter is 0..DEPTH. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Push and pop in the same cycle leave the count unchanged; this is legal at any count below DEPTH.
- `x_full` is registered (count == DEPTH). A pop in the same cycle does not make room for a push; that push is dropped.
- `clear`: both FIFOs empty (pointers and counts to 0) at the edge, and the cycle's inputs are discarded. `last_grant` is kept.
- `rdy` low: no push, no pop, no broadcast, all registers hold.

## Timing
- Reset values: all FIFO pointers and counts 0, `last_grant` = LSB (so the ALU wins the first tie). Outputs: `alu_full` = 0, `lsb_full` = 0, `cdb_valid` = 0, `cdb_rename` = 0, `cdb_value` = 0, `cdb_src` = 0.
- Latency without bypass: a result pushed in cycle t is broadcast no earlier than cycle t+1.
- Worst-case wait for a queued head: one cycle per entry ahead of it in its own FIFO, plus one cycle per alternating grant to the other source.
- Reset asserted mid-operation clears immediately, asynchronously. Queued results are lost; the ROB flushes alongside.

## Configuration
- `CDB_ARB_BYPASS_EN`
  - Defined: if a source's FIFO is empty and that source wins arbitration, its incoming result is broadcast in the same cycle and is not enqueued, giving 0-cycle latency. A bypass candidate competes in round-robin exactly like a head.
  - Undefined: every result passes through its FIFO, so minimum latency is 1 cycle.

## Structure
- Shared package: RENAME_W/DATA_W defaults, `cdb_src` encoding constants (SRC_ALU = 0, SRC_LSB = 1), and a packed result struct {rename, value}.
- Sub-module: `result_fifo`, instantiated twice.
  - Parameters: DEPTH and width.
  - Ports: push/pop, head, count-based `full`/`empty`, `clear`.

## Test plan
- Reset release, idle → `cdb_valid` = 0, both `full` = 0, all bus outputs 0.
- ALU pushes tag 3 / value 0x11 alone in cycle 5 → broadcast in cycle 6 with src 0 (cycle 5 with bypass).
- Both push every cycle for 8 cycles (ALU tags 0..7, LSB tags 8..15) → bus alternates ALU 0, LSB 8, ALU 1, … with no loss. `full` asserts once DEPTH entries are queued; the producer then withholds, and every tag appears exactly once.
- Fill the LSB FIFO to 4, then push while popping → that push is dropped and `lsb_full` stays 1 for that cycle.
- Queue 3 entries in each FIFO, pulse `clear` → next cycle `cdb_valid` = 0 and both FIFOs are empty. A fresh ALU push then broadcasts normally.
- Hold `rdy` low for 3 cycles with 2 entries queued → no broadcasts and no pops. Once `rdy` returns, both entries drain in order.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
// Shared definitions for the result broadcast bus arbiter.
//   RENAME_W_DEF / DATA_W_DEF : default tag and value widths
//   src_e                     : cdb_src encoding (SRC_ALU = 0, SRC_LSB = 1)
//   result_t                  : packed {rename, value} result at default widths
package cdb_arbiter_pkg;

  localparam int RENAME_W_DEF = 4;
  localparam int DATA_W_DEF   = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  typedef struct packed {
    logic [RENAME_W_DEF-1:0] rename;
    logic [DATA_W_DEF-1:0]   value;
  } result_t;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// result_fifo
// Small circular FIFO holding results from one producer until the bus
// arbiter drains them. Full/empty come straight from the registered count.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-low reset
//   push, din     : enqueue din at the edge (ignored when full or clearing)
//   pop           : drop the head at the edge (ignored when empty or clearing)
//   clear         : synchronous flush of pointers and count
//   head          : oldest entry (undefined when empty)
//   full, empty   : count == DEPTH / count == 0
module result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is dropped even if a pop happens in the same
  // cycle: full is a registered view of the count, not of next state.
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Shares the single result broadcast bus between the ALU and the load/store
// buffer. Each producer fills a private result_fifo; a round-robin arbiter
// drains one result per cycle onto the bus.
// Optional feature macro: CDB_ARB_BYPASS_EN
//   When defined, a source whose FIFO is empty and that wins arbitration
//   broadcasts its incoming result in the same cycle without enqueueing it.
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   rdy                               : global enable, low freezes all state
//   clear                             : synchronous flush of both FIFOs
//   alu_valid/alu_rename/alu_value    : ALU result input
//   alu_full                          : ALU FIFO holds DEPTH entries
//   lsb_valid/lsb_rename/lsb_value    : load result input
//   lsb_full                          : LSB FIFO holds DEPTH entries
//   cdb_valid/cdb_rename/cdb_value    : broadcast bus (zero when idle)
//   cdb_src                           : 0 = ALU, 1 = LSB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RENAME_W = RENAME_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                alu_valid,
  input  logic [RENAME_W-1:0] alu_rename,
  input  logic [DATA_W-1:0]   alu_value,
  output logic                alu_full,
  input  logic                lsb_valid,
  input  logic [RENAME_W-1:0] lsb_rename,
  input  logic [DATA_W-1:0]   lsb_value,
  output logic                lsb_full,
  output logic                cdb_valid,
  output logic [RENAME_W-1:0] cdb_rename,
  output logic [DATA_W-1:0]   cdb_value,
  output logic                cdb_src
);

  localparam int W = RENAME_W + DATA_W;

  logic [W-1:0] alu_head;
  logic [W-1:0] lsb_head;
  logic         alu_empty;
  logic         lsb_empty;
  logic         alu_push;
  logic         lsb_push;
  logic         alu_pop;
  logic         lsb_pop;
  logic         alu_cand;
  logic         lsb_cand;
  logic         alu_byp;
  logic         lsb_byp;
  logic         grant_any;
  logic         bus_on;
  logic         fifo_clear;
  src_e         grant_src;
  src_e         last_grant;
  logic [W-1:0] grant_data;

  // Arbitration candidates: a non-empty FIFO head, or with bypass enabled
  // an incoming result arriving at an empty FIFO.
`ifdef CDB_ARB_BYPASS_EN
  assign alu_cand = !alu_empty || alu_valid;
  assign lsb_cand = !lsb_empty || lsb_valid;
`else
  assign alu_cand = !alu_empty;
  assign lsb_cand = !lsb_empty;
`endif

  // Round-robin: on a tie the source not granted last wins.
  always_comb begin
    grant_src = SRC_ALU;
    if (alu_cand && lsb_cand) begin
      grant_src = (last_grant == SRC_LSB) ? SRC_ALU : SRC_LSB;
    end else if (lsb_cand) begin
      grant_src = SRC_LSB;
    end
  end

  assign grant_any = alu_cand || lsb_cand;
  assign bus_on    = rdy && !clear && grant_any;

  // A granted source with an empty FIFO can only be a bypass candidate.
`ifdef CDB_ARB_BYPASS_EN
  assign alu_byp = bus_on && (grant_src == SRC_ALU) && alu_empty;
  assign lsb_byp = bus_on && (grant_src == SRC_LSB) && lsb_empty;
`else
  assign alu_byp = 1'b0;
  assign lsb_byp = 1'b0;
`endif

  always_comb begin
    grant_data = '0;
    if (grant_src == SRC_ALU) begin
      grant_data = alu_byp ? {alu_rename, alu_value} : alu_head;
    end else begin
      grant_data = lsb_byp ? {lsb_rename, lsb_value} : lsb_head;
    end
  end

  // A bypassed result is consumed by the bus, so it must not also enqueue.
  assign alu_push = alu_valid && !alu_full && rdy && !clear && !alu_byp;
  assign lsb_push = lsb_valid && !lsb_full && rdy && !clear && !lsb_byp;
  assign alu_pop  = bus_on && (grant_src == SRC_ALU) && !alu_byp;
  assign lsb_pop  = bus_on && (grant_src == SRC_LSB) && !lsb_byp;

  // With rdy low every register holds, so the flush waits for rdy as well.
  assign fifo_clear = clear && rdy;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (alu_push),
    .pop   (alu_pop),
    .clear (fifo_clear),
    .din   ({alu_rename, alu_value}),
    .head  (alu_head),
    .full  (alu_full),
    .empty (alu_empty)
  );

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .clear (fifo_clear),
    .din   ({lsb_rename, lsb_value}),
    .head  (lsb_head),
    .full  (lsb_full),
    .empty (lsb_empty)
  );

  // Reset favours the ALU on the first tie; a flush keeps the history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= SRC_LSB;
    end else if (bus_on) begin
      last_grant <= grant_src;
    end
  end

  assign cdb_valid  = bus_on;
  assign cdb_src    = bus_on ? logic'(grant_src) : 1'b0;
  assign cdb_rename = bus_on ? grant_data[W-1 -: RENAME_W] : '0;
  assign cdb_value  = bus_on ? grant_data[DATA_W-1:0] : '0;

endmodule
